// File: rtl/game_flow_ctl.sv
// rtl/game_flow_ctl.sv - game sequencer: START/GAME/PLAYER_x state, scores, round timer, round-start pulse
// Optional round timer and timeout path enabled by GAME_TIMER_EN.
module game_flow_ctl #(
    parameter int WIN_SCORE   = 10,
    parameter int FRAME_RATE  = 60,
    parameter int ROUND_SEC   = 60,
    parameter int HOLD_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [1:0] state,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [6:0] time_left,
    output logic       round_start
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_GAME  = 2'b01,
        ST_P1    = 2'b11,
        ST_P2    = 2'b10
    } state_t;

    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [6:0] TIME_INIT = 7'(ROUND_SEC);
    localparam logic [7:0] HOLD_MAX  = 8'(HOLD_FRAMES);

    generate
        if (WIN_SCORE < 1 || WIN_SCORE > 15 || ROUND_SEC < 1 || ROUND_SEC > 127 ||
            HOLD_FRAMES < 1 || HOLD_FRAMES > 255 || FRAME_RATE < 1) begin : g_bad_params
            $error("game_flow_ctl: parameter out of range");
        end
    endgenerate

    state_t     cur, nxt;
    logic       btn_q;
    logic       start_edge;
    logic [3:0] inc1, inc2;
    logic [3:0] s1_n, s2_n;
    logic [6:0] t_n;
    logic [7:0] hold, hold_n;
    logic       rs_n;

`ifdef GAME_TIMER_EN
    localparam int DIV_W = (FRAME_RATE > 1) ? $clog2(FRAME_RATE) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_RATE - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    logic [DIV_W-1:0] div, div_n;
    logic             sec_tick;
    logic             sudden;
`endif

    assign state      = cur;
    assign start_edge = btn_start & ~btn_q;
    assign inc1 = (p1_point && score_p1 != WIN) ? score_p1 + 4'd1 : score_p1;
    assign inc2 = (p2_point && score_p2 != WIN) ? score_p2 + 4'd1 : score_p2;

    always_comb begin
        nxt    = cur;
        s1_n   = score_p1;
        s2_n   = score_p2;
        t_n    = time_left;
        hold_n = hold;
        rs_n   = 1'b0;
`ifdef GAME_TIMER_EN
        div_n    = div;
        sec_tick = 1'b0;
        sudden   = 1'b0;
`endif
        case (cur)
            ST_START: begin
                if (start_edge) begin
                    nxt  = ST_GAME;
                    s1_n = 4'd0;
                    s2_n = 4'd0;
                    t_n  = TIME_INIT;
                    rs_n = 1'b1;
`ifdef GAME_TIMER_EN
                    div_n = '0;
`endif
                end
            end
            ST_GAME: begin
                s1_n = inc1;
                s2_n = inc2;
`ifdef GAME_TIMER_EN
                sudden = (time_left == 7'd0);
                if (frame_tick) begin
                    if (div == DIV_MAX) begin
                        div_n    = '0;
                        sec_tick = 1'b1;
                    end else begin
                        div_n = div + DIV_ONE;
                    end
                end
                if (sec_tick && time_left != 7'd0)
                    t_n = time_left - 7'd1;
`endif
                // Win by score beats any timeout decision in the same cycle.
                if (inc1 == WIN)
                    nxt = ST_P1;
                else if (inc2 == WIN)
                    nxt = ST_P2;
`ifdef GAME_TIMER_EN
                else if (sudden && (p1_point || p2_point))
                    nxt = p1_point ? ST_P1 : ST_P2;
                else if (sec_tick && time_left == 7'd1) begin
                    if (inc1 > inc2)
                        nxt = ST_P1;
                    else if (inc2 > inc1)
                        nxt = ST_P2;
                end
`endif
                if (nxt != ST_GAME)
                    hold_n = 8'd0;
            end
            ST_P1, ST_P2: begin
                if (start_edge && hold == HOLD_MAX)
                    nxt = ST_START;
                else if (frame_tick && hold != HOLD_MAX)
                    hold_n = hold + 8'd1;
            end
            default: nxt = ST_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= ST_START;
            btn_q       <= 1'b0;
            score_p1    <= 4'd0;
            score_p2    <= 4'd0;
            time_left   <= TIME_INIT;
            round_start <= 1'b0;
            hold        <= 8'd0;
`ifdef GAME_TIMER_EN
            div         <= '0;
`endif
        end else begin
            cur         <= nxt;
            btn_q       <= btn_start;
            score_p1    <= s1_n;
            score_p2    <= s2_n;
            time_left   <= t_n;
            round_start <= rs_n;
            hold        <= hold_n;
`ifdef GAME_TIMER_EN
            div         <= div_n;
`endif
        end
    end

endmodule

// File: tb/tb_game_flow_ctl.sv
// tb/tb_game_flow_ctl.sv - randomized and directed bench for game_flow_ctl against a behavioural model
module tb_game_flow_ctl;

    localparam int WIN = 10;
    localparam int FR  = 4;
    localparam int RS  = 2;
    localparam int HF  = 180;
`ifdef GAME_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, btn_start, p1_point, p2_point;
    logic [1:0] state;
    logic [3:0] score_p1, score_p2;
    logic [6:0] time_left;
    logic       round_start;

    int vectors = 0;
    int miscompares = 0;
    bit chk = 1'b0;

    game_flow_ctl #(.WIN_SCORE(WIN), .FRAME_RATE(FR), .ROUND_SEC(RS), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_start(btn_start),
        .p1_point(p1_point), .p2_point(p2_point), .state(state),
        .score_p1(score_p1), .score_p2(score_p2), .time_left(time_left),
        .round_start(round_start)
    );

    always #5 clk = ~clk;

    // Model: phase 0=start 1=game 2=p1 wins 3=p2 wins; seconds counted in frames.
    int m_ph, m_s1, m_s2, m_t, m_hold, m_frames, m_rs;
    bit m_prev;
    int n1, n2;
    bit pressed, timeout, sudden;

    function automatic logic [1:0] bus_of(int ph);
        case (ph)
            1: return 2'b01;
            2: return 2'b11;
            3: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_s1 = 0; m_s2 = 0; m_t = RS; m_hold = 0; m_frames = 0; m_rs = 0; m_prev = 1'b0;
        end else begin
            pressed = btn_start && !m_prev;
            m_prev  = btn_start;
            m_rs    = 0;
            if (m_ph == 0) begin
                if (pressed) begin
                    m_ph = 1; m_s1 = 0; m_s2 = 0; m_t = RS; m_frames = 0; m_rs = 1;
                end
            end else if (m_ph == 1) begin
                n1 = (m_s1 + int'(p1_point) > WIN) ? WIN : m_s1 + int'(p1_point);
                n2 = (m_s2 + int'(p2_point) > WIN) ? WIN : m_s2 + int'(p2_point);
                sudden  = TIMER && (m_t == 0);
                timeout = 1'b0;
                if (TIMER && frame_tick) begin
                    m_frames++;
                    if (m_frames % FR == 0) begin
                        if (m_t == 1) timeout = 1'b1;
                        if (m_t > 0) m_t--;
                    end
                end
                if (n1 == WIN) m_ph = 2;
                else if (n2 == WIN) m_ph = 3;
                else if (sudden && (p1_point || p2_point)) m_ph = p1_point ? 2 : 3;
                else if (timeout && n1 != n2) m_ph = (n1 > n2) ? 2 : 3;
                m_s1 = n1;
                m_s2 = n2;
                if (m_ph != 1) m_hold = 0;
            end else begin
                if (pressed && m_hold == HF) m_ph = 0;
                else if (frame_tick && m_hold < HF) m_hold++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            vectors++;
            if (state !== bus_of(m_ph) || score_p1 !== 4'(m_s1) || score_p2 !== 4'(m_s2) ||
                time_left !== 7'(m_t) || round_start !== 1'(m_rs)) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t got st=%b s1=%0d s2=%0d t=%0d rs=%b want st=%b s1=%0d s2=%0d t=%0d rs=%0d",
                         $time, state, score_p1, score_p2, time_left, round_start,
                         bus_of(m_ph), m_s1, m_s2, m_t, m_rs);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic ft, input logic a1, input logic a2);
        btn_start = b; frame_tick = ft; p1_point = a1; p2_point = a2;
        @(negedge clk);
    endtask

    task automatic to_game();
        for (int i = 0; i <= HF; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int rs_cnt;
    logic b;

    initial begin
        rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
        @(negedge clk);
        chk = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", 32'(state), 32'h0);
        check("reset_scores", 32'({score_p1, score_p2}), 32'h0);
        check("reset_time", 32'(time_left), 32'(RS));
        check("reset_round_start", 32'(round_start), 32'h0);
        rst = 1'b0;

        rs_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (round_start === 1'b1) rs_cnt++;
            if (i == 0) check("state_after_edge", 32'(state), 32'h1);
        end
        check("one_round_start", 32'(rs_cnt), 32'd1);
        check("start_time", 32'(time_left), 32'(RS));
        step(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 8) check("p1_at_9_still_game", 32'(state), 32'h1);
            if (i == 1 || i == 4 || i == 7) step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("p1_win_state", 32'(state), 32'h3);
        check("p1_win_score", 32'(score_p1), 32'd10);
        check("p2_score_3", 32'(score_p2), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("p2_frozen", 32'(score_p2), 32'd3);

        to_game();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("p2_win_state", 32'(state), 32'h2);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("early_start_ignored", 32'(state), 32'h2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_done_to_start", 32'(state), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_game", 32'(state), 32'h1);
        check("restart_scores", 32'({score_p1, score_p2}), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("tie_win_scores", 32'({score_p1, score_p2}), 32'hAA);
        check("tie_win_p1_priority", 32'(state), 32'h3);

`ifdef GAME_TIMER_EN
        to_game();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("timer_one_sec", 32'(time_left), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("timeout_time", 32'(time_left), 32'd0);
        check("timeout_p1_leads", 32'(state), 32'h3);
        to_game();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("sudden_death_state", 32'(state), 32'h1);
        check("sudden_death_time", 32'(time_left), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sudden_death_p2", 32'(state), 32'h2);
`endif

        to_game();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("pre_reset_scores", 32'({score_p1, score_p2}), 32'h57);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("midgame_reset_state", 32'(state), 32'h0);
        check("midgame_reset_scores", 32'({score_p1, score_p2}), 32'h0);
        check("midgame_reset_time", 32'(time_left), 32'(RS));
        check("midgame_reset_rs", 32'(round_start), 32'h0);

        b = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 15) == 0) b = ~b;
            step(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 5) == 0));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
